// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller: FSM state
// encoding, XALU op codes and the md-class decode helper.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BUSY  = 2'd2
    } md_state_e;

    localparam logic [3:0] MD_OP_NONE  = 4'd0;
    localparam logic [3:0] MD_OP_MULT  = 4'd1;
    localparam logic [3:0] MD_OP_MULTU = 4'd2;
    localparam logic [3:0] MD_OP_DIV   = 4'd3;
    localparam logic [3:0] MD_OP_DIVU  = 4'd4;

    // An instruction in D is md-class if it starts an XALU op or touches HI/LO.
    function automatic logic is_md_class(input logic [3:0] op,
                                         input logic       mf,
                                         input logic       mt);
        return (op != MD_OP_NONE) || mf || mt;
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline <-> issue-controller signal bundle. The pipeline side (master) drives
// decode/execute status and XALU busy; the controller (slave) returns stall/status.
interface md_issue_ctrl_if #(
    parameter int CNT_W = 32
) ();
    import md_pkg::*;

    // Level signals, no handshake: every input is sampled each cycle and every
    // output is valid in the same cycle (stall_md/md_active are combinational).
    logic [3:0]       md_op_D;
    logic             mf_D;
    logic             mt_D;
    logic             start_E;
    logic             busy;
    logic             stall_md;
    logic             md_active;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;
    md_state_e        dbg_state;

    modport master (
        output md_op_D, mf_D, mt_D, start_E, busy,
        input  stall_md, md_active, md_err, stall_cnt, dbg_state
    );

    modport slave (
        input  md_op_D, mf_D, mt_D, start_E, busy,
        output stall_md, md_active, md_err, stall_cnt, dbg_state
    );

endinterface

// File: rtl/md_perf_cnt.sv
// Free-running stall-cycle counter, only instantiated when MD_PERF_EN is defined.
// Wraps naturally at 2^CNT_W.
module md_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: tracks an outstanding XALU op and stalls D on
// md-class instructions. Define MD_PERF_EN to build the stall-cycle counter.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MAX_CYC = 16,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           reset,
    md_issue_ctrl_if.slave bus
);

    localparam int              BC_W   = $clog2(MAX_CYC + 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_CYC);

    md_state_e       state_q;
    md_state_e       state_d;
    md_state_e       state_eff;
    logic [BC_W-1:0] bcnt_q;
    logic [BC_W-1:0] bcnt_d;
    logic            err_q;
    logic            err_d;
    logic            active;
    logic            stall;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_E) begin
                    state_d = ST_ARMED;
                end else if (bus.busy) begin
                    // Busy without a start means the XALU and pipeline disagree.
                    state_d = ST_BUSY;
                    err_d   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (bus.start_E) begin
                    err_d = 1'b1;
                end
                state_d = bus.busy ? ST_BUSY : ST_IDLE;
            end
            ST_BUSY: begin
                if (bus.start_E) begin
                    err_d = 1'b1;
                end
                if (bus.busy) begin
                    if (bcnt_q != BC_MAX) begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                    if (bcnt_d == BC_MAX) begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_BUSY) && (state_q != ST_BUSY)) begin
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    // While reset is held the combinational outputs already behave as in IDLE.
    assign state_eff = reset ? ST_IDLE : state_q;
    assign active    = (state_eff != ST_IDLE) || bus.start_E;
    assign stall     = is_md_class(bus.md_op_D, bus.mf_D, bus.mt_D) && active;

    assign bus.md_active = active;
    assign bus.stall_md  = stall;
    assign bus.md_err    = err_q;
    assign bus.dbg_state = state_q;

`ifdef MD_PERF_EN
    md_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (stall),
        .cnt_o (bus.stall_cnt)
    );
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: mult/div stalls, zero-latency op, reset
// mid-operation, protocol errors and busy timeout.
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_issue_ctrl_if #(.CNT_W(32)) bus ();

    md_issue_ctrl #(
        .MAX_CYC (16),
        .CNT_W   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp   = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check outputs 1ns later.
    task automatic cyc(input string tag, input logic [3:0] op, input logic mf,
                       input logic mt, input logic st, input logic bz, input logic rst,
                       input logic e_stall, input logic e_active, input logic e_err);
        @(negedge clk);
        bus.md_op_D = op;
        bus.mf_D    = mf;
        bus.mt_D    = mt;
        bus.start_E = st;
        bus.busy    = bz;
        reset       = rst;
        #1;
        chk({tag, ".stall"},  32'(bus.stall_md),  32'(e_stall));
        chk({tag, ".active"}, 32'(bus.md_active), 32'(e_active));
        chk({tag, ".err"},    32'(bus.md_err),    32'(e_err));
        chk({tag, ".cnt"},    bus.stall_cnt,      exp_cnt);
`ifdef MD_PERF_EN
        if (rst) exp_cnt = '0;
        else if (e_stall) exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    initial begin
        reset       = 1'b1;
        bus.md_op_D = MD_OP_NONE;
        bus.mf_D    = 1'b0;
        bus.mt_D    = 1'b0;
        bus.start_E = 1'b0;
        bus.busy    = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        cyc("rst_state", MD_OP_NONE, F, F, F, F, F, F, F, F);

        // mult followed by mfhi: stall while op outstanding, release after busy falls
        cyc("mult_c0", MD_OP_NONE, F, F, T, F, F, F, T, F);
        for (int i = 1; i <= 5; i++)
            cyc($sformatf("mult_c%0d", i), MD_OP_NONE, T, F, F, T, F, T, T, F);
        cyc("mult_c6", MD_OP_NONE, T, F, F, F, F, T, T, F);
        cyc("mult_c7", MD_OP_NONE, T, F, F, F, F, F, F, F);

        // div back-to-back with another div waiting in D
        cyc("div_c0", MD_OP_NONE, F, F, T, F, F, F, T, F);
        for (int i = 1; i <= 10; i++)
            cyc($sformatf("div_c%0d", i), MD_OP_DIV, F, F, F, T, F, T, T, F);
        cyc("div_c11", MD_OP_DIV, F, F, F, F, F, T, T, F);
        cyc("div_c12", MD_OP_DIV, F, F, F, F, F, F, F, F);

        // Non-md instruction in D while busy: no stall, still active
        cyc("nomd_c0", MD_OP_NONE, F, F, T, F, F, F, T, F);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("nomd_c%0d", i), MD_OP_NONE, F, F, F, T, F, F, T, F);
        cyc("nomd_c5", MD_OP_NONE, F, F, F, F, F, F, T, F);
        cyc("nomd_c6", MD_OP_NONE, F, F, F, F, F, F, F, F);

        // Stray start in BUSY flags error; reset at busy cycle 3 abandons the op
        cyc("rmid_c0", MD_OP_MULTU, F, F, T, F, F, T, T, F);
        cyc("rmid_c1", MD_OP_NONE, T, F, F, T, F, T, T, F);
        cyc("rmid_c2", MD_OP_NONE, T, F, T, T, F, T, T, F);
        cyc("rmid_c3", MD_OP_NONE, T, F, F, T, T, F, F, T);
        cyc("rmid_c4", MD_OP_NONE, T, F, F, F, F, F, F, F);
        cyc("rmid_c5", MD_OP_NONE, T, F, T, F, F, T, T, F);
        // Zero-latency op: ARMED with busy low returns to IDLE
        cyc("rmid_c6", MD_OP_NONE, F, F, F, F, F, F, T, F);
        cyc("rmid_c7", MD_OP_NONE, F, F, F, F, F, F, F, F);

        // Busy without a prior start
        cyc("orph_c0", MD_OP_NONE, F, F, F, T, F, F, F, F);
        cyc("orph_c1", MD_OP_NONE, F, T, F, F, F, T, T, T);
        cyc("orph_c2", MD_OP_NONE, F, F, F, F, F, F, F, T);
        cyc("orph_c3", MD_OP_NONE, F, F, F, F, T, F, F, T);
        cyc("orph_c4", MD_OP_NONE, F, F, F, F, F, F, F, F);

        // Busy stuck high 20 cycles: error appears in BUSY cycle 17 and sticks
        cyc("tmo_c0", MD_OP_NONE, F, F, T, F, F, F, T, F);
        for (int i = 1; i <= 20; i++)
            cyc($sformatf("tmo_c%0d", i), MD_OP_NONE, F, F, F, T, F, F, T, (i >= 18) ? T : F);
        cyc("tmo_c21", MD_OP_NONE, F, F, F, F, F, F, T, T);
        cyc("tmo_c22", MD_OP_NONE, F, F, F, F, F, F, F, T);
        cyc("tmo_c23", MD_OP_NONE, F, F, F, F, T, F, F, T);
        cyc("tmo_c24", MD_OP_NONE, F, F, F, F, F, F, F, F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
